// File: rtl/result_display_scanner.sv
// result_display_scanner
// Captures ALU result/error/command through a ready/valid load port and
// scans a 4-digit common-segment 7-seg display: command (hex), blank,
// result tens, result ones. New data is committed only at frame boundaries.
module result_display_scanner #(
  parameter int REFRESH_DIV        = 1000,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] result,
  input  logic       error,
  input  logic [3:0] command,
  input  logic       load,
  output logic       loadReady,
  output logic [6:0] display,
  output logic [3:0] digitEnable,
  output logic       frameTick
);

  localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]     GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0]     GLYPH_E     = 7'b1111001;
  localparam logic [6:0]     GLYPH_ONE   = 7'b0000110;
  localparam logic [6:0]     GLYPH_ZERO  = 7'b0111111;

  // Hex digit to segment pattern (bit 0 = segment a).
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b0111111;
      4'h1:    g = 7'b0000110;
      4'h2:    g = 7'b1011011;
      4'h3:    g = 7'b1001111;
      4'h4:    g = 7'b1100110;
      4'h5:    g = 7'b1101101;
      4'h6:    g = 7'b1111101;
      4'h7:    g = 7'b0000111;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1101111;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b1111100;
      4'hC:    g = 7'b0111001;
      4'hD:    g = 7'b1011110;
      4'hE:    g = 7'b1111001;
      4'hF:    g = 7'b1110001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Units digit of a 0..15 value; the range never needs more than one subtraction.
  function automatic logic [3:0] ones_of(input logic [3:0] r);
    logic [3:0] o;
    if (r >= 4'd10) begin
      o = r - 4'd10;
    end else begin
      o = r;
    end
    return o;
  endfunction

  // Segment pattern for one digit position given the committed values.
  function automatic logic [6:0] digit_glyph(input logic [1:0] sel, input logic [3:0] r,
                                             input logic e, input logic [3:0] c);
    logic [6:0] g;
    case (sel)
      2'd0: begin
        if (e) g = GLYPH_BLANK;
        else   g = hex_glyph(ones_of(r));
      end
      2'd1: begin
        if (e)                       g = GLYPH_E;
        else if (r >= 4'd10)         g = GLYPH_ONE;
        else if (BLANK_LEADING_ZERO) g = GLYPH_BLANK;
        else                         g = GLYPH_ZERO;
      end
      2'd2:    g = GLYPH_BLANK;
      2'd3:    g = hex_glyph(c);
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  logic [PW-1:0] r_presc;
  logic [1:0]    r_dsel;
  logic          r_pending;
  logic          r_load_ready;
  logic [3:0]    r_sh_result;
  logic          r_sh_error;
  logic [3:0]    r_sh_command;
  logic [3:0]    r_cm_result;
  logic          r_cm_error;
  logic [3:0]    r_cm_command;
  logic [6:0]    r_display;
  logic [3:0]    r_digit_en;

  logic          w_presc_tc;
  logic          w_frame_tick;
  logic          w_commit;
  logic          w_accept;

  // Terminal-count, frame boundary and handshake decode.
  always_comb begin
    w_presc_tc   = (r_presc == PRESC_LAST);
    w_frame_tick = w_presc_tc && (r_dsel == 2'd3);
    w_commit     = w_frame_tick && r_pending;
    w_accept     = load && r_load_ready;
  end

  // Prescaler: holds each digit for REFRESH_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Digit selector advances once per prescaler wrap, modulo 4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dsel <= 2'd0;
    end else if (w_presc_tc) begin
      r_dsel <= r_dsel + 2'd1;
    end else begin
      r_dsel <= r_dsel;
    end
  end

  // Load capture into shadow registers and frame-aligned commit. A commit
  // needs pending=1 which forces ready=0, so capture and commit never collide;
  // a capture on a frame-tick edge therefore waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_load_ready <= 1'b1;
      r_sh_result  <= 4'd0;
      r_sh_error   <= 1'b0;
      r_sh_command <= 4'd0;
      r_cm_result  <= 4'd0;
      r_cm_error   <= 1'b0;
      r_cm_command <= 4'd0;
    end else if (w_commit) begin
      r_cm_result  <= r_sh_result;
      r_cm_error   <= r_sh_error;
      r_cm_command <= r_sh_command;
      r_pending    <= 1'b0;
      r_load_ready <= 1'b1;
    end else if (w_accept) begin
      r_sh_result  <= result;
      r_sh_error   <= error;
      r_sh_command <= command;
      r_pending    <= 1'b1;
      r_load_ready <= 1'b0;
    end else begin
      r_pending    <= r_pending;
      r_load_ready <= r_load_ready;
    end
  end

  // Registered display drive: one clock behind the digit selector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_display  <= 7'b0000000;
      r_digit_en <= 4'b0000;
    end else begin
      r_display  <= digit_glyph(r_dsel, r_cm_result, r_cm_error, r_cm_command);
      r_digit_en <= 4'b0001 << r_dsel;
    end
  end

  assign display     = r_display;
  assign digitEnable = r_digit_en;
  assign loadReady   = r_load_ready;
  assign frameTick   = w_frame_tick;

endmodule
